sp_ram_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port RAM (write-first-priority, registered read address, 1-cycle read latency) between NUM_REQ requesters.
- Sits between client blocks and the RAM instance; drives the RAM's data/addr/we pins and returns read data tagged to the granted requester.
- One access per cycle; no stalls beyond arbitration loss.

---
 rtl/sp_ram_arbiter.sv | 95 +++++++++
 tb/tb_sp_ram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read latency) between NUM_REQ clients.
// Grant and RAM drive are combinational; read-valid and requester id are registered.
module sp_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ID_WIDTH-1:0]           rid,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_data,
  input  logic [DATA_WIDTH-1:0]         ram_q
);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] win;
  logic                any_gnt;
  int unsigned         scan_idx;

  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;

  // Scan from the priority pointer; the first requester found wins.
  always_comb begin
    scan_idx = 0;
    win      = '0;
    any_gnt  = 1'b0;
    gnt      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!any_gnt && req[scan_idx]) begin
        any_gnt = 1'b1;
        win     = ID_WIDTH'(scan_idx);
      end
    end
    if (any_gnt) begin
      gnt[win] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      ptr_d = (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Idle cycles park the RAM on address 0 with the write disabled.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (any_gnt) begin
      ram_we   = req_we[win];
      ram_addr = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
      ram_data = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rvalid_d = gnt & ~req_we;
    rid_d    = rid_q;
    if (any_gnt && !req_we[win]) begin
      rid_d = win;
    end
  end

  // A write granted during reset still reaches the RAM; only the response state is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rid_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rid    = rid_q;
  assign rdata  = ram_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port RAM model attached.
module tb_sp_ram_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt, rvalid;
  logic [DW-1:0]    rdata;
  logic [IW-1:0]    rid;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_data, ram_q;

  always #5 clk = ~clk;

  sp_ram_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rid      (rid),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_q    (ram_q)
  );

  // RAM: registered read address, write-first.
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] mem_addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    mem_addr_q <= ram_addr;
  end
  assign ram_q = mem[mem_addr_q];

  typedef struct {
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR-1:0]    we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]    e_gnt;
    logic             e_we;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_data;
    logic [NR-1:0]    e_rvalid;
    logic [IW-1:0]    e_rid;
    logic [DW-1:0]    e_rdata;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [NR*AW-1:0] pa(input logic [AW-1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [NR*DW-1:0] pd(input logic [DW-1:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic r, input logic [NR-1:0] rq, w,
                              input logic [NR*AW-1:0] a, input logic [NR*DW-1:0] d,
                              input logic [NR-1:0] eg, input logic ew,
                              input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                              input logic [NR-1:0] erv, input logic [IW-1:0] eid,
                              input logic [DW-1:0] erd);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.addr = a; v.wdata = d;
    v.e_gnt = eg; v.e_we = ew; v.e_addr = ea; v.e_data = ed;
    v.e_rvalid = erv; v.e_rid = eid; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the edge, check at the falling edge.
  task automatic cyc(input string tag, input vec_t v);
    rst       = v.rst;
    req       = v.req;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    chk({tag, " gnt"}, 32'(gnt), 32'(v.e_gnt));
    chk({tag, " ram_we"}, 32'(ram_we), 32'(v.e_we));
    chk({tag, " ram_addr"}, 32'(ram_addr), 32'(v.e_addr));
    if (v.e_we) chk({tag, " ram_data"}, 32'(ram_data), 32'(v.e_data));
    chk({tag, " rvalid"}, 32'(rvalid), 32'(v.e_rvalid));
    chk({tag, " rid"}, 32'(rid), 32'(v.e_rid));
    if (v.e_rvalid != '0) chk({tag, " rdata"}, 32'(rdata), 32'(v.e_rdata));
    @(posedge clk);
    #1;
  endtask

  localparam logic [NR*AW-1:0] A0123 = {6'd3, 6'd2, 6'd1, 6'd0};
  localparam logic [NR*DW-1:0] D0    = '0;

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, then idle.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // Req 2 writes 0xA5 @5, req 1 reads it back.
    tbl.push_back(mk(0, 4'b0100, 4'b0100, pa(0, 5, 0, 0), pd(0, 8'hA5, 0, 0),
                     4'b0100, 1, 5, 8'hA5, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, pa(0, 0, 5, 0), D0, 4'b0010, 0, 5, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b0010, 1, 8'hA5));
    // Preload 0..3 with 0x10..0x13 through requester 0.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4'b0001, 4'b0001, pa(0, 0, 0, AW'(i)), pd(0, 0, 0, DW'(8'h10 + i)),
                       4'b0001, 1, AW'(i), DW'(8'h10 + i), 4'b0000, 1, 0));
    // Read by 3 moves the pointer back to 0.
    tbl.push_back(mk(0, 4'b1000, 4'b0000, A0123, D0, 4'b1000, 0, 3, 0, 4'b0000, 1, 0));
    // All four read continuously: rotation 0,1,2,3,...
    for (int i = 0; i < 8; i++) begin
      int p;
      p = (i + 3) % 4;
      tbl.push_back(mk(0, 4'b1111, 4'b0000, A0123, D0, NR'(1 << (i % 4)), 0, AW'(i % 4), 0,
                       NR'(1 << p), IW'(p), DW'(8'h10 + p)));
    end
    tbl.push_back(mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b1000, 3, 8'h13));
    // 0 and 3 contend with ptr=0: 0 first, 3 waits one cycle.
    tbl.push_back(mk(0, 4'b1001, 4'b0000, A0123, D0, 4'b0001, 0, 0, 0, 4'b0000, 3, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, A0123, D0, 4'b1000, 0, 3, 0, 4'b0001, 0, 8'h10));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b1000, 3, 8'h13));

    foreach (tbl[i]) cyc($sformatf("row%0d", i), tbl[i]);

    // Read then write to the same address: read sees the old value, next read the new one.
    cyc("raw1", mk(0, 4'b0010, 4'b0010, pa(0, 0, 9, 0), pd(0, 0, 8'h55, 0),
                   4'b0010, 1, 9, 8'h55, 4'b0000, 3, 0));
    cyc("raw2", mk(0, 4'b0010, 4'b0000, pa(0, 0, 9, 0), D0, 4'b0010, 0, 9, 0, 4'b0000, 3, 0));
    cyc("raw3", mk(0, 4'b0100, 4'b0100, pa(0, 9, 0, 0), pd(0, 8'h3C, 0, 0),
                   4'b0100, 1, 9, 8'h3C, 4'b0010, 1, 8'h55));
    cyc("raw4", mk(0, 4'b0010, 4'b0000, pa(0, 0, 9, 0), D0, 4'b0010, 0, 9, 0, 4'b0000, 1, 0));
    cyc("raw5", mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b0010, 1, 8'h3C));

    // Reset during a read grant: no rvalid, pointer back to 0.
    cyc("rst1", mk(1, 4'b0001, 4'b0000, A0123, D0, 4'b0001, 0, 0, 0, 4'b0000, 1, 0));
    cyc("rst2", mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    cyc("rst3", mk(0, 4'b1111, 4'b0000, A0123, D0, 4'b0001, 0, 0, 0, 4'b0000, 0, 0));
    cyc("rst4", mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b0001, 0, 8'h10));
    // Write granted during reset still lands in the RAM.
    cyc("rstw1", mk(1, 4'b0100, 4'b0100, pa(0, 20, 0, 0), pd(0, 8'h77, 0, 0),
                    4'b0100, 1, 20, 8'h77, 4'b0000, 0, 0));
    cyc("rstw2", mk(0, 4'b0010, 4'b0000, pa(0, 0, 20, 0), D0, 4'b0010, 0, 20, 0, 4'b0000, 0, 0));
    cyc("rstw3", mk(0, 4'b0000, 4'b0000, '0, D0, 4'b0000, 0, 0, 0, 4'b0010, 1, 8'h77));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
